// File: rtl/ifetch_ctrl_if.sv
// Fetch-controller bus: PC generator link, instruction memory channel and execute handoff.
// The master modport is the fetch controller; slave is its environment.
interface ifetch_ctrl_if;
   logic [31:0] i_pc;
   logic        o_pc_en;
   logic        i_flush;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        o_instr_vld;
   logic [31:0] o_instr;
   logic [31:0] o_instr_pc;
   logic        o_instr_fault;
   logic [1:0]  o_fault_cause;
   logic        i_instr_rdy;

   modport master (
      input  i_pc, i_flush, i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_instr_rdy,
      output o_pc_en, o_imem_req, o_imem_addr, o_instr_vld, o_instr, o_instr_pc,
             o_instr_fault, o_fault_cause
   );

   modport slave (
      output i_pc, i_flush, i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_instr_rdy,
      input  o_pc_en, o_imem_req, o_imem_addr, o_instr_vld, o_instr, o_instr_pc,
             o_instr_fault, o_fault_cause
   );
endinterface

// File: rtl/ifetch_ctrl.sv
// Single-outstanding instruction fetch controller: issues one request per PC, holds the
// result (or a NOP fault entry) until execute accepts it, and gates the PC generator.
module ifetch_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
   input logic           i_clk,
   input logic           i_rst,
   ifetch_ctrl_if.master bus
);

   typedef enum logic [2:0] {StIdle, StReq, StWait, StDrop, StHold} state_e;

   localparam logic [15:0] CntLast = 16'(TIMEOUT_CYC - 1);

   state_e      state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic        fault_q, fault_d;
   logic [1:0]  cause_q, cause_d;
   logic [15:0] cnt_q, cnt_d;
   logic        aligned;
   logic        timeout;

   assign aligned = (bus.i_pc[1:0] == 2'b00);
   assign timeout = (cnt_q == CntLast);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q    <= StIdle;
         instr_q    <= 32'h0;
         instr_pc_q <= 32'h0;
         fault_q    <= 1'b0;
         cause_q    <= 2'b00;
         cnt_q      <= 16'h0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         fault_q    <= fault_d;
         cause_q    <= cause_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      instr_d         = instr_q;
      instr_pc_d      = instr_pc_q;
      fault_d         = fault_q;
      cause_d         = cause_q;
      cnt_d           = cnt_q;
      bus.o_pc_en     = 1'b0;
      bus.o_imem_req  = 1'b0;
      bus.o_imem_addr = 32'h0;

      unique case (state_q)
         StIdle: state_d = StReq;

         StReq: begin
            if (aligned) begin
               bus.o_imem_req  = 1'b1;
               bus.o_imem_addr = bus.i_pc;
               bus.o_pc_en     = bus.i_flush;
               if (bus.i_imem_gnt) begin
                  instr_pc_d = bus.i_pc;
                  cnt_d      = 16'h0;
                  // A granted request under flush still owes a response, so drain it.
                  state_d    = bus.i_flush ? StDrop : StWait;
               end
            end else if (bus.i_flush) begin
               bus.o_pc_en = 1'b1;
            end else begin
               state_d    = StHold;
               fault_d    = 1'b1;
               cause_d    = 2'b01;
               instr_d    = NOP_INSTR;
               instr_pc_d = bus.i_pc;
            end
         end

         StWait: begin
            if (bus.i_flush) begin
               bus.o_pc_en = 1'b1;
               state_d     = bus.i_imem_rvalid ? StReq : StDrop;
            end else if (bus.i_imem_rvalid) begin
               state_d = StHold;
               instr_d = bus.i_imem_rdata;
               fault_d = 1'b0;
               cause_d = 2'b00;
            end else if (timeout) begin
               state_d = StHold;
               fault_d = 1'b1;
               cause_d = 2'b10;
               instr_d = NOP_INSTR;
            end else begin
               cnt_d = cnt_q + 16'h1;
            end
         end

         StDrop: begin
            bus.o_pc_en = bus.i_flush;
            if (bus.i_imem_rvalid) begin
               state_d = StReq;
            end
         end

         StHold: begin
            if (bus.i_instr_rdy || bus.i_flush) begin
               bus.o_pc_en = 1'b1;
               state_d     = StReq;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // Held-entry outputs are only meaningful in HOLD; elsewhere they read as zero.
   assign bus.o_instr_vld   = (state_q == StHold);
   assign bus.o_instr       = (state_q == StHold) ? instr_q : 32'h0;
   assign bus.o_instr_pc    = (state_q == StHold) ? instr_pc_q : 32'h0;
   assign bus.o_instr_fault = (state_q == StHold) ? fault_q : 1'b0;
   assign bus.o_fault_cause = (state_q == StHold) ? cause_q : 2'b00;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: table of fetch transactions plus hand-written flush/reset sequences,
// with a scoreboard of expected held entries compared on acceptance.
module tb_ifetch_ctrl;

   localparam int TO = 4;

   typedef struct {
      logic [31:0] pc;
      int          gnt_dly;
      int          rsp_dly;
      logic [31:0] rdata;
      int          rdy_dly;
      logic [31:0] exp_instr;
      logic        exp_fault;
      logic [1:0]  exp_cause;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
      logic [1:0]  cause;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   pc_en_cnt = 0;
   exp_t sb[$];
   vec_t vecs[6];

   ifetch_ctrl_if bus ();

   ifetch_ctrl #(
      .TIMEOUT_CYC(TO),
      .NOP_INSTR  (32'h0000_0013)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor for the settled cycle, then advance to the next negedge.
   task automatic tick();
      exp_t e;
      if (bus.o_pc_en) pc_en_cnt++;
      if (bus.o_instr_vld && bus.i_flush) begin
         if (sb.size() > 0) e = sb.pop_front();
      end else if (bus.o_instr_vld && bus.i_instr_rdy) begin
         chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("acc_instr", bus.o_instr, e.instr);
            chk("acc_pc", bus.o_instr_pc, e.pc);
            chk("acc_fault", 32'(bus.o_instr_fault), 32'(e.fault));
            chk("acc_cause", 32'(bus.o_fault_cause), 32'(e.cause));
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.i_imem_gnt    = 1'b0;
      bus.i_imem_rvalid = 1'b0;
      bus.i_imem_rdata  = 32'h0;
      bus.i_instr_rdy   = 1'b0;
      bus.i_flush       = 1'b0;
   endtask

   // One fetch starting with the DUT in REQ and ending back in REQ after acceptance.
   task automatic fetch(input vec_t v);
      exp_t e;
      int   n0;
      n0 = pc_en_cnt;
      idle_inputs();
      bus.i_pc = v.pc;
      e.instr  = v.exp_instr;
      e.pc     = v.pc;
      e.fault  = v.exp_fault;
      e.cause  = v.exp_cause;
      if (v.pc[1:0] != 2'b00) begin
         #1;
         chk("mis_no_req", 32'(bus.o_imem_req), 32'd0);
         sb.push_back(e);
         tick();
      end else begin
         for (int k = 0; k < v.gnt_dly; k++) begin
            #1;
            chk("stall_req_pcen", 32'({bus.o_imem_req, bus.o_pc_en}), 32'b10);
            chk("stall_addr", bus.o_imem_addr, v.pc);
            tick();
         end
         bus.i_imem_gnt = 1'b1;
         #1;
         chk("gnt_req", 32'(bus.o_imem_req), 32'd1);
         chk("gnt_addr", bus.o_imem_addr, v.pc);
         tick();
         bus.i_imem_gnt = 1'b0;
         for (int k = 0; k < TO && k <= v.rsp_dly; k++) begin
            if (k == v.rsp_dly) begin
               bus.i_imem_rvalid = 1'b1;
               bus.i_imem_rdata  = v.rdata;
               sb.push_back(e);
            end
            #1;
            chk("wait_req_vld", 32'({bus.o_imem_req, bus.o_instr_vld}), 32'd0);
            tick();
         end
         bus.i_imem_rvalid = 1'b0;
         if (v.rsp_dly >= TO) sb.push_back(e);
      end
      for (int k = 0; k < v.rdy_dly; k++) begin
         #1;
         chk("hold_vld", 32'(bus.o_instr_vld), 32'd1);
         chk("hold_instr", bus.o_instr, e.instr);
         chk("hold_pcen_req", 32'({bus.o_pc_en, bus.o_imem_req}), 32'd0);
         tick();
      end
      bus.i_instr_rdy = 1'b1;
      #1;
      chk("acc_pcen", 32'(bus.o_pc_en), 32'd1);
      tick();
      bus.i_instr_rdy = 1'b0;
      chk("pcen_once", 32'(pc_en_cnt - n0), 32'd1);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_req_vld_pcen"},
          32'({bus.o_imem_req, bus.o_instr_vld, bus.o_pc_en}), 32'd0);
      chk({tag, "_instr"}, bus.o_instr, 32'h0);
      chk({tag, "_instr_pc"}, bus.o_instr_pc, 32'h0);
      chk({tag, "_fault_cause"}, 32'({bus.o_instr_fault, bus.o_fault_cause}), 32'd0);
   endtask

   initial begin
      int n0;
      vecs[0] = '{32'h0,   0, 0,  32'h0050_0093, 0, 32'h0050_0093, 1'b0, 2'b00};
      vecs[1] = '{32'h4,   3, 1,  32'h00A0_0113, 5, 32'h00A0_0113, 1'b0, 2'b00};
      vecs[2] = '{32'h102, 0, 0,  32'h0,         2, 32'h0000_0013, 1'b1, 2'b01};
      vecs[3] = '{32'h8,   0, TO, 32'h0,         1, 32'h0000_0013, 1'b1, 2'b10};
      vecs[4] = '{32'hC,   0, 3,  32'h1234_5678, 0, 32'h1234_5678, 1'b0, 2'b00};
      vecs[5] = '{32'h10,  2, 2,  32'hCAFE_F00D, 3, 32'hCAFE_F00D, 1'b0, 2'b00};

      idle_inputs();
      bus.i_pc = 32'h0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk_zero_outputs("reset");
      rst = 1'b1;
      #1;
      chk_zero_outputs("idle");
      tick();

      foreach (vecs[i]) fetch(vecs[i]);

      // Flush in WAIT, stale DEADBEEF response two cycles later, refetch at redirect target.
      n0 = pc_en_cnt;
      idle_inputs();
      bus.i_pc = 32'h100;
      bus.i_imem_gnt = 1'b1;
      #1;
      tick();
      bus.i_imem_gnt = 1'b0;
      bus.i_flush = 1'b1;
      #1;
      chk("wflush_pcen", 32'(bus.o_pc_en), 32'd1);
      tick();
      bus.i_flush = 1'b0;
      bus.i_pc = 32'h200;
      #1;
      chk("drop_req_vld", 32'({bus.o_imem_req, bus.o_instr_vld}), 32'd0);
      tick();
      bus.i_imem_rvalid = 1'b1;
      bus.i_imem_rdata  = 32'hDEAD_BEEF;
      #1;
      chk("drop_rsp_req_vld", 32'({bus.o_imem_req, bus.o_instr_vld}), 32'd0);
      tick();
      bus.i_imem_rvalid = 1'b0;
      chk("wflush_pcen_once", 32'(pc_en_cnt - n0), 32'd1);
      fetch('{32'h200, 0, 0, 32'h0000_0293, 1, 32'h0000_0293, 1'b0, 2'b00});

      // Flush while holding, with rdy also high: entry is discarded.
      idle_inputs();
      bus.i_pc = 32'h300;
      bus.i_imem_gnt = 1'b1;
      #1;
      tick();
      bus.i_imem_gnt = 1'b0;
      bus.i_imem_rvalid = 1'b1;
      bus.i_imem_rdata  = 32'h1111_1111;
      sb.push_back('{32'h1111_1111, 32'h300, 1'b0, 2'b00});
      #1;
      tick();
      bus.i_imem_rvalid = 1'b0;
      bus.i_flush = 1'b1;
      bus.i_instr_rdy = 1'b1;
      #1;
      chk("hflush_vld_pcen", 32'({bus.o_instr_vld, bus.o_pc_en}), 32'b11);
      tick();
      idle_inputs();
      #1;
      chk("hflush_gone", 32'({bus.o_instr_vld, bus.o_imem_req}), 32'b01);

      // Flush in REQ without grant stays in REQ; grant under flush drains via DROP.
      bus.i_pc = 32'h400;
      bus.i_flush = 1'b1;
      #1;
      chk("rflush_req_pcen", 32'({bus.o_imem_req, bus.o_pc_en}), 32'b11);
      tick();
      bus.i_imem_gnt = 1'b1;
      #1;
      chk("rflush_gnt_pcen", 32'(bus.o_pc_en), 32'd1);
      tick();
      idle_inputs();
      bus.i_imem_rvalid = 1'b1;
      bus.i_imem_rdata  = 32'h2222_2222;
      #1;
      chk("rflush_drop", 32'({bus.o_imem_req, bus.o_instr_vld, bus.o_pc_en}), 32'd0);
      tick();
      bus.i_imem_rvalid = 1'b0;

      // Reset while in WAIT, stray responses in IDLE/REQ, then a fresh fetch from 0.
      bus.i_pc = 32'h40;
      bus.i_imem_gnt = 1'b1;
      #1;
      tick();
      bus.i_imem_gnt = 1'b0;
      rst = 1'b0;
      #1;
      tick();
      rst = 1'b1;
      bus.i_pc = 32'h0;
      bus.i_imem_rvalid = 1'b1;
      bus.i_imem_rdata  = 32'h3333_3333;
      #1;
      chk_zero_outputs("rst_idle");
      tick();
      #1;
      chk("rst_req", 32'(bus.o_imem_req), 32'd1);
      chk("rst_addr", bus.o_imem_addr, 32'h0);
      chk("rst_stray_vld", 32'(bus.o_instr_vld), 32'd0);
      tick();
      bus.i_imem_rvalid = 1'b0;
      fetch('{32'h0, 0, 0, 32'h0050_0093, 0, 32'h0050_0093, 1'b0, 2'b00});

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
